// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types for the forwarding/hazard unit: forward-select encodings,
// load-wait FSM states and the default register address type.
package lc3b_types;

  localparam int unsigned LC3B_REG_AW = 3;

  typedef logic [LC3B_REG_AW-1:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EXME    = 2'd1,
    FWD_MEWB    = 2'd2,
    FWD_HOLD    = 2'd3
  } fwd_sel_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_LD_WAIT = 1'b1
  } ld_state_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit: stage inputs and
// forward/stall outputs.
interface fwd_hazard_unit_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned DW      = 16,
  parameter int unsigned CNT_W   = 16
);
  logic [NUM_SRC-1:0][REG_AW-1:0] src_addr;
  logic [NUM_SRC-1:0]             src_used;
  logic                           exme_ld_dest;
  logic                           exme_is_load;
  logic [REG_AW-1:0]              exme_dest;
  logic                           mem_resp;
  logic                           mewb_ld_dest;
  logic [REG_AW-1:0]              mewb_dest;
  logic [DW-1:0]                  mewb_data;
  logic [NUM_SRC-1:0][1:0]        fwd_sel;
  logic [DW-1:0]                  hold_data;
  logic                           stall_out;
  logic [CNT_W-1:0]               stall_cnt;

  modport master (
    output src_addr, src_used, exme_ld_dest, exme_is_load, exme_dest,
           mem_resp, mewb_ld_dest, mewb_dest, mewb_data,
    input  fwd_sel, hold_data, stall_out, stall_cnt
  );

  modport slave (
    input  src_addr, src_used, exme_ld_dest, exme_is_load, exme_dest,
           mem_resp, mewb_ld_dest, mewb_dest, mewb_data,
    output fwd_sel, hold_data, stall_out, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_match.sv
// Per-source priority compare: EX/MEM over MEM/WB over the hold entry.
module fwd_match
  import lc3b_types::*;
#(
  parameter int unsigned REG_AW = 3
) (
  input  logic              used,
  input  logic [REG_AW-1:0] addr,
  input  logic              exme_ld_dest,
  input  logic [REG_AW-1:0] exme_dest,
  input  logic              mewb_ld_dest,
  input  logic [REG_AW-1:0] mewb_dest,
  input  logic              hold_valid,
  input  logic [REG_AW-1:0] hold_dest,
  output fwd_sel_t          sel_c,
  output logic              exme_hit_c
);

  always_comb begin
    sel_c      = FWD_REGFILE;
    exme_hit_c = used && exme_ld_dest && (addr == exme_dest);
    if (used) begin
      if (exme_hit_c)
        sel_c = FWD_EXME;
      else if (mewb_ld_dest && (addr == mewb_dest))
        sel_c = FWD_MEWB;
      else if (hold_valid && (addr == hold_dest))
        sel_c = FWD_HOLD;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select, writeback hold entry and load-use stall control
// with a saturating stall-cycle counter.
module fwd_hazard_unit
  import lc3b_types::*;
#(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned DW      = 16,
  parameter int unsigned CNT_W   = 16
) (
  input logic             clk,
  input logic             rst,
  fwd_hazard_unit_if.slave bus
);

  logic              hold_valid;
  logic [REG_AW-1:0] hold_dest;
  logic [DW-1:0]     hold_data_q;
  logic [CNT_W-1:0]  cnt_q;
  ld_state_t         state;

  logic [NUM_SRC-1:0][1:0] sel_w;
  logic [NUM_SRC-1:0]      exme_hit;
  logic                    hazard_c;

  // Most recent writeback, kept so a later consumer can still pick it up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid  <= 1'b0;
      hold_dest   <= '0;
      hold_data_q <= '0;
    end else if (bus.mewb_ld_dest) begin
      hold_valid  <= 1'b1;
      hold_dest   <= bus.mewb_dest;
      hold_data_q <= bus.mewb_data;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_match #(.REG_AW(REG_AW)) u_match (
      .used         (bus.src_used[g]),
      .addr         (bus.src_addr[g]),
      .exme_ld_dest (bus.exme_ld_dest),
      .exme_dest    (bus.exme_dest),
      .mewb_ld_dest (bus.mewb_ld_dest),
      .mewb_dest    (bus.mewb_dest),
      .hold_valid   (hold_valid),
      .hold_dest    (hold_dest),
      .sel_c        (sel_w[g]),
      .exme_hit_c   (exme_hit[g])
    );
  end

  // Stall drops in the response cycle so the load data flows through EX/MEM select
  assign hazard_c = bus.exme_ld_dest && bus.exme_is_load && (|exme_hit) && !bus.mem_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      cnt_q <= '0;
    end else begin
      case (state)
        ST_RUN:     if (hazard_c)     state <= ST_LD_WAIT;
        ST_LD_WAIT: if (bus.mem_resp) state <= ST_RUN;
        default:                      state <= ST_RUN;
      endcase
      if (hazard_c && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_sel   = sel_w;
  assign bus.hold_data = hold_data_q;
  assign bus.stall_out = hazard_c;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of source operands checked per consuming instruction.
REQ-002 SHALL have parameter REG_AW, default 3, register address width.
REQ-003 SHALL have parameter DW, default 16, data width.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 src_addr  input  NUM_SRC x REG_AW  register addresses read by the instruction in ID/EX.
REQ-008 src_used  input  NUM_SRC  per-source flag: operand actually consumed (decoded upstream).
REQ-009 exme_ld_dest, exme_is_load  input  1 each  EX/MEM writes a register; the write is a load.
REQ-010 exme_dest  input  REG_AW  EX/MEM destination.
REQ-011 mem_resp  input  1  data-memory response for the EX/MEM load is valid this cycle.
REQ-012 mewb_ld_dest  input  1; mewb_dest  input  REG_AW; mewb_data  input  DW  writeback stage.
REQ-013 fwd_sel  output  NUM_SRC x 2  per source: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 hold.
REQ-014 hold_data  output  DW  data of hold entry.
REQ-015 stall_out  output  1  freeze IF/ID and ID/EX; bubble EX/MEM.
REQ-016 stall_cnt  output  CNT_W  load-use stall cycles counted.

Function
REQ-017 Hold entry {valid, dest, data} SHALL load {1, mewb_dest, mewb_data} at every edge with mewb_ld_dest=1, else retain.
REQ-018 Per source i with src_used[i]=1: fwd_sel[i] SHALL be 1 if exme_ld_dest and exme_dest match, else 2 if mewb_ld_dest and mewb_dest match, else 3 if hold valid and hold dest match, else 0.
REQ-019 fwd_sel[i] SHALL be 0 when src_used[i]=0; fwd_sel is combinational from inputs and hold state.
REQ-020 Load-use hazard SHALL be: exme_ld_dest & exme_is_load & any used source matching exme_dest & !mem_resp.
REQ-021 FSM states RUN and LD_WAIT; RUN -> LD_WAIT on hazard; LD_WAIT -> RUN on mem_resp; else hold state.
REQ-022 stall_out SHALL be 1 combinationally whenever a hazard exists (RUN or LD_WAIT), 0 in the mem_resp cycle.
REQ-023 In the mem_resp cycle matching sources SHALL select 1 (external mux carries load data).
REQ-024 stall_cnt SHALL increment once per cycle with stall_out=1 and saturate at all-ones.
REQ-025 Multiple sources matching the same producer SHALL all receive the same select.
REQ-026 mem_resp while no hazard SHALL not change state or counter.

Reset
REQ-027 rst SHALL immediately force: FSM RUN, hold valid 0, hold dest 0, hold_data 0, stall_cnt 0.
REQ-028 Outputs during reset: fwd_sel per REQ-018 with hold invalid; stall_out per REQ-020.
REQ-029 Reset mid-LD_WAIT SHALL abandon the wait; no counter carry-over.

Structure
REQ-030 fwd_sel encodings and FSM state enum SHALL live in lc3b_types; lc3b_reg remains REG_AW=3 default.
REQ-031 One sub-module fwd_match (per-source priority compare) SHALL be instantiated NUM_SRC times by generate.

Verification
REQ-032 hold R3=0x1234 via mewb; next cycle src0=R3, no other matches -> fwd_sel[0]=3, hold_data=0x1234.
REQ-033 exme_dest=R2 and mewb_dest=R2 both writing, src1=R2 -> fwd_sel[1]=1 (EX/MEM priority).
REQ-034 exme load to R5, src0=R5, mem_resp low 3 cycles then high -> stall_out 1,1,1,0; stall_cnt=3; fwd_sel[0]=1 at resp.
REQ-035 src_used=3'b100, all addresses equal exme_dest -> fwd_sel={1,0,0}; load variant stalls only via src2.
REQ-036 Force stall_cnt to all-ones, extra stall cycle -> stays all-ones.
REQ-037 Assert rst during LD_WAIT -> state RUN, stall_cnt=0, hold invalid asynchronously before next edge.
